neuron_stream_loader: RTL

Sequential front end and compute stage for one 4-input neuron. It accepts a byte stream over a valid/ready handshake and assembles one frame of inputs, weights and bias. It evaluates the neuron with one multiply-accumulate per cycle, clamps the sum and returns an 8-bit signed result over a second valid/ready handshake. It is the upstream writer that replaces file-driven operand loading when neurons are fed from a bus or FIFO.

---
 rtl/neuron_stream_loader.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/neuron_stream_loader.sv
// ---------------------------------------------------------------------------
// neuron_stream_loader
//
// Byte-stream front end and sequential compute stage for one N-input neuron.
// A frame of X1..XN, W1..WN, bias_lo, bias_hi is collected over a
// valid/ready byte handshake. The neuron is then evaluated with one
// multiply-accumulate per cycle. The sum is clamped to [xmin, xmax] and to
// the int8 range, and the result is returned over a second valid/ready
// handshake.
//
// Optional feature (compile-time macro):
//   NEURON_RELU_EN  - when defined, the clamped result passes through ReLU
//                     (negative results become 0). Timing is unchanged.
//
// Parameters:
//   N_INPUTS  number of X/W pairs per frame (1..16)
//   ACC_W     accumulator width, >= 16 + clog2(N_INPUTS) + 2
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    stream byte
//   in_valid   in_data valid
//   in_ready   loader accepts a byte this cycle (LOAD state only)
//   xmin/xmax  signed clamp bounds, sampled with the frame's last byte
//   y          signed 8-bit neuron result
//   out_valid  y valid
//   out_ready  consumer accepts y
//   busy       high while computing or holding a result
//   frame_cnt  completed output handshakes, wraps at 256
// ---------------------------------------------------------------------------
module neuron_stream_loader #(
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [11:0] xmin,
    input  logic signed [11:0] xmax,
    output logic signed [7:0]  y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic [7:0]         frame_cnt
);

    localparam int FRAME_LEN = 2 * N_INPUTS + 2;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int MAC_W     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] BIAS_LO_IDX = IDX_W'(2 * N_INPUTS);
    localparam logic [MAC_W-1:0] LAST_MAC    = MAC_W'(N_INPUTS - 1);

    localparam logic signed [11:0] C_LO = -12'sd128;
    localparam logic signed [11:0] C_HI = 12'sd127;

    typedef enum logic [1:0] {
        S_LOAD,
        S_MAC,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [IDX_W-1:0]        r_idx;
    logic [MAC_W-1:0]        r_mac;
    logic signed [7:0]       r_x [N_INPUTS];
    logic signed [7:0]       r_w [N_INPUTS];
    logic [7:0]              r_bias_lo;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [11:0]      r_xmin;
    logic signed [11:0]      r_xmax;
    logic signed [7:0]       r_y;
    logic                    r_out_valid;
    logic [7:0]              r_frame_cnt;

    logic                    w_in_ready;
    logic                    w_busy;
    logic                    w_accept;
    logic signed [7:0]       w_xsel;
    logic signed [7:0]       w_wsel;
    logic signed [15:0]      w_prod;
    logic signed [15:0]      w_bias;
    logic signed [ACC_W-1:0] w_acc_sum;
    logic signed [11:0]      w_lo;
    logic signed [11:0]      w_hi;
    logic signed [ACC_W-1:0] w_lo_ext;
    logic signed [ACC_W-1:0] w_hi_ext;
    logic signed [ACC_W-1:0] w_upper;
    logic signed [ACC_W-1:0] w_clamped;
    logic signed [7:0]       w_y_next;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake/status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (in_valid && (r_idx == LAST_IDX)) begin
                    w_state_next = S_MAC;
                end
            end
            S_MAC: begin
                w_busy = 1'b1;
                if (r_mac == LAST_MAC) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                w_busy = 1'b1;
                // out_valid is always high in this state
                if (out_ready) begin
                    w_state_next = S_LOAD;
                end
            end
            default: w_state_next = S_LOAD;
        endcase
    end

    assign w_accept = in_valid && (r_state == S_LOAD);

    // ------------------------------------------------------------------
    // Operand select for the current MAC step
    // ------------------------------------------------------------------
    always_comb begin
        w_xsel = '0;
        w_wsel = '0;
        for (int unsigned i = 0; i < N_INPUTS; i++) begin
            if (r_mac == MAC_W'(i)) begin
                w_xsel = r_x[i];
                w_wsel = r_w[i];
            end
        end
    end

    assign w_prod    = w_xsel * w_wsel;
    assign w_acc_sum = r_acc + {{(ACC_W-16){w_prod[15]}}, w_prod};
    assign w_bias    = {in_data, r_bias_lo};

    // ------------------------------------------------------------------
    // Clamp: bounds limited to int8 first; upper bound applied before the
    // lower one so an inverted window (lo > hi) yields lo.
    // ------------------------------------------------------------------
    assign w_lo     = (r_xmin < C_LO) ? C_LO : r_xmin;
    assign w_hi     = (r_xmax > C_HI) ? C_HI : r_xmax;
    assign w_lo_ext = {{(ACC_W-12){w_lo[11]}}, w_lo};
    assign w_hi_ext = {{(ACC_W-12){w_hi[11]}}, w_hi};

    always_comb begin
        w_upper   = (w_acc_sum > w_hi_ext) ? w_hi_ext : w_acc_sum;
        w_clamped = (w_upper < w_lo_ext) ? w_lo_ext : w_upper;
`ifdef NEURON_RELU_EN
        w_y_next  = w_clamped[ACC_W-1] ? 8'sd0 : w_clamped[7:0];
`else
        w_y_next  = w_clamped[7:0];
`endif
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_mac       <= '0;
            r_bias_lo   <= '0;
            r_acc       <= '0;
            r_xmin      <= '0;
            r_xmax      <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
            r_frame_cnt <= '0;
            for (int unsigned i = 0; i < N_INPUTS; i++) begin
                r_x[i] <= '0;
                r_w[i] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        for (int unsigned i = 0; i < N_INPUTS; i++) begin
                            if (r_idx == IDX_W'(i)) begin
                                r_x[i] <= in_data;
                            end
                            if (r_idx == IDX_W'(N_INPUTS + i)) begin
                                r_w[i] <= in_data;
                            end
                        end
                        if (r_idx == BIAS_LO_IDX) begin
                            r_bias_lo <= in_data;
                        end
                        if (r_idx == LAST_IDX) begin
                            r_idx  <= '0;
                            r_mac  <= '0;
                            r_acc  <= {{(ACC_W-16){w_bias[15]}}, w_bias};
                            r_xmin <= xmin;
                            r_xmax <= xmax;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_sum;
                    if (r_mac == LAST_MAC) begin
                        r_mac       <= '0;
                        r_y         <= w_y_next;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_mac <= r_mac + MAC_W'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign busy      = w_busy;
    assign y         = r_y;
    assign out_valid = r_out_valid;
    assign frame_cnt = r_frame_cnt;

endmodule
